data_mem_responder: RTL and testbench

- Responder end of the CPU data-memory port.
- Accepts the MEM-stage address, store data and write enable from the CPU and returns load data on the same cycle, so the MEM/WB pipe register captures it at the next CLK edge.
- Holds the data RAM array and, when compiled in, a small memory-mapped I/O window: free-running cycle counter, LED register, synchronised switch inputs and a store counter.
- Sits beside the CPU at top level, wired directly to its data_mem_* ports.

---
 rtl/data_mem_responder.sv | 98 +++++++++
 tb/tb_data_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: async-read/sync-write RAM plus, with DMEM_MMIO_EN defined,
// an MMIO window at address bit 31 (cycle counter, LEDs, synchronised switches, store counter).
module data_mem_responder #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LED_W = 8,
  parameter int unsigned SW_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N-1:0]     data_mem_address_i,
  input  logic [N-1:0]     data_mem_in_data_i,
  input  logic             data_mem_WE_i,
  output logic [N-1:0]     data_mem_out_data_o,
  output logic [LED_W-1:0] led_o,
  input  logic [SW_W-1:0]  sw_i
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] idx;
  logic          mmio_sel;
  logic          ram_we;
  logic [N-1:0]  ram_rd;
  logic [N-1:0]  mmio_rd;
  logic          unused_bits;

  assign idx    = data_mem_address_i[AW-1:0];
  assign ram_rd = mem[idx];

`ifdef DMEM_MMIO_EN
  logic [N-1:0]     cycle_cnt;
  logic [N-1:0]     store_cnt;
  logic [LED_W-1:0] led_reg;
  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [1:0]       reg_sel;
  logic             mmio_we;

  assign mmio_sel = data_mem_address_i[N-1];
  assign reg_sel  = data_mem_address_i[1:0];
  assign mmio_we  = data_mem_WE_i && mmio_sel;

  // MMIO register file; a RAM store counts toward store_cnt, saturating at all-ones
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cycle_cnt <= '0;
      store_cnt <= '0;
      led_reg   <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + N'(1);
      sw_meta   <= sw_i;
      sw_sync   <= sw_meta;
      if (mmio_we && reg_sel == 2'd1) led_reg <= data_mem_in_data_i[LED_W-1:0];
      if (mmio_we && reg_sel == 2'd3) begin
        store_cnt <= data_mem_in_data_i;
      end else if (ram_we && store_cnt != '1) begin
        store_cnt <= store_cnt + N'(1);
      end
    end
  end

  always_comb begin
    mmio_rd = '0;
    case (reg_sel)
      2'd0:    mmio_rd = cycle_cnt;
      2'd1:    mmio_rd = N'(led_reg);
      2'd2:    mmio_rd = N'(sw_sync);
      default: mmio_rd = store_cnt;
    endcase
  end

  assign led_o       = led_reg;
  assign unused_bits = ^data_mem_address_i[N-2:AW];
`else
  assign mmio_sel    = 1'b0;
  assign mmio_rd     = '0;
  assign led_o       = '0;
  assign unused_bits = ^{data_mem_address_i[N-1:AW], sw_i};
`endif

  assign ram_we = data_mem_WE_i && !mmio_sel;

  // RAM contents are not reset; stores are suppressed while RST is high
  always_ff @(posedge CLK) begin
    if (ram_we && !RST) mem[idx] <= data_mem_in_data_i;
  end

  always_comb begin
    data_mem_out_data_o = ram_rd;
    if (mmio_sel) data_mem_out_data_o = mmio_rd;
    if (RST)      data_mem_out_data_o = '0;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + randomized bench for data_mem_responder against a behavioural memory/MMIO model.
module tb_data_mem_responder;

  logic        CLK;
  logic        RST;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we;
  logic [31:0] dout;
  logic [7:0]  led;
  logic [7:0]  sw;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [31:0] m_mem [1024];
  logic [31:0] m_cyc;
  logic [31:0] m_st;
  logic [7:0]  m_led;
  logic [7:0]  m_s1;
  logic [7:0]  m_s2;

  data_mem_responder dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .data_mem_address_i  (addr),
    .data_mem_in_data_i  (din),
    .data_mem_WE_i       (we),
    .data_mem_out_data_o (dout),
    .led_o               (led),
    .sw_i                (sw)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_st = 0; m_led = 0; m_s1 = 0; m_s2 = 0;
  endtask

  function automatic logic [31:0] model_out(input logic [31:0] a);
    if (RST) return 32'h0;
`ifdef DMEM_MMIO_EN
    if (a[31]) begin
      case (a[1:0])
        2'd0:    return m_cyc;
        2'd1:    return {24'h0, m_led};
        2'd2:    return {24'h0, m_s2};
        default: return m_st;
      endcase
    end
`endif
    return m_mem[a % 1024];
  endfunction

  // Advance one clock edge and apply the same edge to the model using the held inputs.
  task automatic tick();
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else begin
`ifdef DMEM_MMIO_EN
      if (we && addr[31]) begin
        if (addr[1:0] == 2'd1) m_led = din[7:0];
        if (addr[1:0] == 2'd3) m_st = din;
      end else if (we) begin
        m_mem[addr % 1024] = din;
        if (m_st != 32'hFFFF_FFFF) m_st = m_st + 1;
      end
      m_s2 = m_s1;
      m_s1 = sw;
      m_cyc = m_cyc + 1;
`else
      if (we) m_mem[addr % 1024] = din;
`endif
    end
    #1;
  endtask

  task automatic check_now(input string tag);
    #1;
    chk(tag, dout, model_out(addr));
    chk({tag, "_led"}, {24'h0, led}, {24'h0, m_led});
  endtask

  initial begin
    RST = 1'b0; addr = 0; din = 0; we = 0; sw = 0;
    model_reset();
    #2 RST = 1'b1;
    #1;
    chk("rst_out", dout, 32'h0);
    chk("rst_led", {24'h0, led}, 32'h0);
    // writes during reset are dropped
    addr = 32'h8000_0001; din = 32'hFF; we = 1'b1;
    tick();
    tick();
    chk("rst_wr_led", {24'h0, led}, 32'h0);
    we = 1'b0; addr = 32'h8000_0000;
    RST = 1'b0;
    check_now("cyc_first");
`ifdef DMEM_MMIO_EN
    chk("cyc0", dout, 32'h0);
    repeat (5) tick();
    chk("cyc5", dout, 32'd5);
`endif

    // store then load, plus index wrap
    addr = 32'h5; din = 32'hDEADBEEF; we = 1'b1;
    tick();
    we = 1'b0;
    check_now("ld5");
    chk("ld5_const", dout, 32'hDEADBEEF);
    addr = 32'h405;
    check_now("ld405");
    chk("ld405_const", dout, 32'hDEADBEEF);

    // same-cycle read and write of one word returns old data
    addr = 32'h7; din = 32'hA5A5A5A5; we = 1'b1;
    tick();
    din = 32'h1;
    #1 chk("rw_old", dout, 32'hA5A5A5A5);
    tick();
    we = 1'b0;
    check_now("rw_new");
    chk("rw_new_const", dout, 32'h1);

`ifdef DMEM_MMIO_EN
    addr = 32'h8000_0001; din = 32'h1FF; we = 1'b1;
    tick();
    we = 1'b0;
    check_now("led_rd");
    chk("led_ff", {24'h0, led}, 32'hFF);
    chk("led_rd_const", dout, 32'hFF);
    addr = 32'h8000_0000; din = 32'h1234; we = 1'b1;
    tick();
    we = 1'b0;
    check_now("cyc_nowr");

    sw = 8'h3C; addr = 32'h8000_0002;
    tick();
    check_now("sw_edge1");
    tick();
    check_now("sw_edge2");
    chk("sw_const", dout, 32'h3C);

    addr = 32'h8000_0003; din = 32'h0; we = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      addr = 32'h10 + i; din = $urandom; we = 1'b1;
      tick();
    end
    we = 1'b0; addr = 32'h8000_0003;
    check_now("st3");
    chk("st3_const", dout, 32'd3);
    din = 32'hFFFF_FFFF; we = 1'b1;
    tick();
    addr = 32'h20; din = 32'h5; we = 1'b1;
    tick();
    we = 1'b0; addr = 32'h8000_0003;
    check_now("st_sat");
    chk("st_sat_const", dout, 32'hFFFF_FFFF);
`else
    addr = 32'h8000_0001; din = 32'h77; we = 1'b1;
    tick();
    we = 1'b0; addr = 32'h1;
    check_now("nommio_ld1");
    chk("nommio_const", dout, 32'h77);
    chk("nommio_led", {24'h0, led}, 32'h0);
`endif

    // prefill indices 0..15 so every random read has a known expectation
    for (int i = 0; i < 16; i++) begin
      addr = i; din = $urandom; we = 1'b1;
      tick();
    end
    we = 1'b0;

    for (int i = 0; i < 300; i++) begin
      addr = $urandom & 32'hFFFF_FC0F;
      din  = $urandom;
      we   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      check_now("rand");
      tick();
    end

    // asynchronous reset mid-cycle; RAM store under reset is suppressed
    addr = 32'h3; we = 1'b0;
    #2 RST = 1'b1;
    model_reset();
    check_now("async_rst");
    chk("async_rst_out", dout, 32'h0);
    din = 32'hCAFEF00D; we = 1'b1;
    tick();
    we = 1'b0;
    RST = 1'b0;
    check_now("rst_ram_keep");
`ifdef DMEM_MMIO_EN
    addr = 32'h8000_0000;
    check_now("rst_cyc0");
    addr = 32'h8000_0003;
    check_now("rst_st0");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
